// File: rtl/rx_buf_pkg.sv
// Shared constants, write-side state encoding and the channel-count clamp
// for the receive sample packer.
package rx_buf_pkg;

  localparam int MAX_CH         = 8;
  localparam int PKT_WORDS_DEF  = 256;
  localparam int DEPTH_LOG2_DEF = 12;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PACK = 1'b1
  } pack_state_e;

  // Requests above the physical channel count pack all eight channels.
  function automatic logic [3:0] clamp_channels(input logic [3:0] req);
    logic [3:0] res;
    if (req > 4'(MAX_CH)) begin
      res = 4'(MAX_CH);
    end else begin
      res = req;
    end
    return res;
  endfunction

endpackage

// File: rtl/rx_sample_packer_if.sv
// Sample-side and reader-side signals of the packer.
// The master drives samples and read requests; the slave is the packer.
interface rx_sample_packer_if;
  logic        strobe;
  logic [3:0]  channels;
  logic [15:0] din0;
  logic [15:0] din1;
  logic [15:0] din2;
  logic [15:0] din3;
  logic [15:0] din4;
  logic [15:0] din5;
  logic [15:0] din6;
  logic [15:0] din7;
  logic        rd_req;
  logic        clear_status;
  logic [15:0] dout;
  logic        packet_rdy;
  logic        overflow;
  logic [15:0] debugbus;

  modport master (
    output strobe, channels, din0, din1, din2, din3, din4, din5, din6, din7,
    output rd_req, clear_status,
    input  dout, packet_rdy, overflow, debugbus
  );

  modport slave (
    input  strobe, channels, din0, din1, din2, din3, din4, din5, din6, din7,
    input  rd_req, clear_status,
    output dout, packet_rdy, overflow, debugbus
  );
endinterface

// File: rtl/rx_sample_packer_fifo.sv
// Single-clock RAM FIFO of 16-bit words with a registered read port.
// Writes when full and reads when empty are ignored.
module sync_fifo_16 #(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  wr_en,
  input  logic [15:0]           wr_data,
  input  logic                  rd_en,
  output logic [15:0]           dout,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam logic [DEPTH_LOG2:0] DEPTH_WORDS = (DEPTH_LOG2 + 1)'(1) << DEPTH_LOG2;

  logic [15:0]           r_mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic [15:0]           r_dout;
  logic                  w_wr;
  logic                  w_rd;

  assign full  = (r_count == DEPTH_WORDS);
  assign empty = (r_count == (DEPTH_LOG2 + 1)'(0));
  assign w_wr  = wr_en & ~full;
  assign w_rd  = rd_en & ~empty;
  assign count = r_count;
  assign dout  = r_dout;

  // Storage array, left unreset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy and the read register.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_dout   <= 16'h0000;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
        r_dout   <= r_mem[r_rd_ptr];
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (DEPTH_LOG2 + 1)'(1);
        2'b01:   r_count <= r_count - (DEPTH_LOG2 + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/rx_sample_packer.sv
// Captures up to eight channel samples per strobe and serialises them into a
// FIFO read out by the USB side in fixed-size packets.
module rx_sample_packer
  import rx_buf_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int PKT_WORDS  = PKT_WORDS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bus_reset,
  rx_sample_packer_if.slave    bus
);

  localparam logic [DEPTH_LOG2:0] DEPTH_WORDS = (DEPTH_LOG2 + 1)'(1) << DEPTH_LOG2;

  pack_state_e         r_state;
  pack_state_e         w_state_nxt;
  logic [15:0]         r_din [MAX_CH];
  logic [15:0]         w_din_in [MAX_CH];
  logic [3:0]          r_ch_cnt;
  logic [2:0]          r_idx;
  logic [2:0]          w_idx_nxt;
  logic                r_overflow;
  logic                w_srst;
  logic [3:0]          w_ch_clamp;
  logic                w_latch;
  logic                w_drop;
  logic                w_wr_en;
  logic [15:0]         w_wr_data;
  logic [15:0]         w_fifo_dout;
  logic [DEPTH_LOG2:0] w_count;
  logic [DEPTH_LOG2:0] w_free;
  logic                w_full;
  logic                w_empty;
  logic                w_packet_rdy;

  assign w_srst     = reset | bus_reset;
  assign w_ch_clamp = clamp_channels(bus.channels);
  assign w_free     = DEPTH_WORDS - w_count;

  assign w_din_in[0] = bus.din0;
  assign w_din_in[1] = bus.din1;
  assign w_din_in[2] = bus.din2;
  assign w_din_in[3] = bus.din3;
  assign w_din_in[4] = bus.din4;
  assign w_din_in[5] = bus.din5;
  assign w_din_in[6] = bus.din6;
  assign w_din_in[7] = bus.din7;

  sync_fifo_16 #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk     (clk),
    .srst    (w_srst),
    .wr_en   (w_wr_en),
    .wr_data (w_wr_data),
    .rd_en   (bus.rd_req),
    .dout    (w_fifo_dout),
    .count   (w_count),
    .full    (w_full),
    .empty   (w_empty)
  );

  // Packer next state: admit a whole frame only if it fits, else drop it.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_latch     = 1'b0;
    w_drop      = 1'b0;
    w_wr_en     = 1'b0;
    w_wr_data   = r_din[r_idx];
    case (r_state)
      IDLE: begin
        if (bus.strobe && (w_ch_clamp != 4'd0)) begin
          if (w_free >= (DEPTH_LOG2 + 1)'(w_ch_clamp)) begin
            w_latch     = 1'b1;
            w_state_nxt = PACK;
            w_idx_nxt   = 3'd0;
          end else begin
            w_drop = 1'b1;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      PACK: begin
        w_wr_en = 1'b1;
        w_drop  = bus.strobe;
        if ({1'b0, r_idx} == (r_ch_cnt - 4'd1)) begin
          w_state_nxt = IDLE;
          w_idx_nxt   = 3'd0;
        end else begin
          w_idx_nxt = r_idx + 3'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_idx_nxt   = 3'd0;
      end
    endcase
  end

  // Packer state, latched frame and sticky overflow (set beats clear).
  always_ff @(posedge clk) begin
    if (w_srst) begin
      r_state    <= IDLE;
      r_idx      <= 3'd0;
      r_ch_cnt   <= 4'd0;
      r_overflow <= 1'b0;
      for (int i = 0; i < MAX_CH; i++) begin
        r_din[i] <= 16'h0000;
      end
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (w_latch) begin
        r_ch_cnt <= w_ch_clamp;
        for (int i = 0; i < MAX_CH; i++) begin
          r_din[i] <= w_din_in[i];
        end
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (bus.clear_status) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign w_packet_rdy   = (w_count >= (DEPTH_LOG2 + 1)'(PKT_WORDS));
  assign bus.dout       = w_fifo_dout;
  assign bus.packet_rdy = w_packet_rdy;
  assign bus.overflow   = r_overflow;
  assign bus.debugbus   = {r_overflow, w_packet_rdy, w_empty, w_full,
                           (r_state == PACK), w_count[10:0]};

endmodule

// File: tb/tb_rx_sample_packer.sv
// Directed bench for rx_sample_packer: packing order, packet threshold,
// overflow on a full FIFO and on back-to-back strobes, channel clamping, resets.
module tb_rx_sample_packer;

  logic clk = 1'b0;
  logic reset;
  logic bus_reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  rx_sample_packer_if rx_if ();

  rx_sample_packer #(.DEPTH_LOG2(12), .PKT_WORDS(256)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus_reset (bus_reset),
    .bus       (rx_if)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_din(input logic [15:0] base);
    rx_if.din0 = base + 16'd0;
    rx_if.din1 = base + 16'd1;
    rx_if.din2 = base + 16'd2;
    rx_if.din3 = base + 16'd3;
    rx_if.din4 = base + 16'd4;
    rx_if.din5 = base + 16'd5;
    rx_if.din6 = base + 16'd6;
    rx_if.din7 = base + 16'd7;
  endtask

  task automatic send_frame(input int n_after);
    rx_if.strobe = 1'b1;
    tick();
    rx_if.strobe = 1'b0;
    repeat (n_after) tick();
  endtask

  task automatic read_word();
    rx_if.rd_req = 1'b1;
    tick();
    rx_if.rd_req = 1'b0;
  endtask

  initial begin
    reset              = 1'b1;
    bus_reset          = 1'b0;
    rx_if.strobe       = 1'b0;
    rx_if.channels     = 4'd0;
    rx_if.rd_req       = 1'b0;
    rx_if.clear_status = 1'b0;
    set_din(16'h0000);
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // reset state
    check_eq("rst_dout", 32'(rx_if.dout), 32'h0000);
    check_eq("rst_ovf", 32'(rx_if.overflow), 32'h0);
    check_eq("rst_prdy", 32'(rx_if.packet_rdy), 32'h0);
    check_eq("rst_dbg", 32'(rx_if.debugbus), 32'h2000);

    // one 4-channel frame: one word per clock after the strobe
    rx_if.channels = 4'd4;
    set_din(16'h0001);
    send_frame(0);
    check_eq("f4_start", 32'(rx_if.debugbus), 32'h2800);
    tick();
    check_eq("f4_w1", 32'(rx_if.debugbus), 32'h0801);
    repeat (2) tick();
    check_eq("f4_w3", 32'(rx_if.debugbus), 32'h0803);
    tick();
    check_eq("f4_done", 32'(rx_if.debugbus), 32'h0004);
    for (int i = 0; i < 4; i++) begin
      read_word();
      check_eq("f4_rd", 32'(rx_if.dout), 32'(i + 1));
    end
    check_eq("f4_prdy", 32'(rx_if.packet_rdy), 32'h0);

    // 64 frames of 4 words reach exactly one packet
    for (int k = 0; k < 63; k++) begin
      set_din(16'(k * 16));
      send_frame(63);
    end
    check_eq("pkt_252", 32'(rx_if.debugbus), 32'h00FC);
    set_din(16'(63 * 16));
    send_frame(3);
    check_eq("pkt_255", 32'(rx_if.debugbus), 32'h08FF);
    tick();
    check_eq("pkt_256", 32'(rx_if.debugbus), 32'h4100);
    for (int w = 0; w < 256; w++) begin
      read_word();
      check_eq("pkt_rd", 32'(rx_if.dout), 32'((w / 4) * 16 + (w % 4)));
      if (w == 0) begin
        check_eq("pkt_prdy_fall", 32'(rx_if.packet_rdy), 32'h0);
      end
    end
    check_eq("pkt_empty", 32'(rx_if.debugbus), 32'h2000);

    // fill to 4094 with no reads, then a 4-word frame cannot fit
    rx_if.channels = 4'd8;
    for (int k = 0; k < 511; k++) begin
      set_din(16'(k));
      send_frame(8);
    end
    rx_if.channels = 4'd6;
    send_frame(6);
    check_eq("fill_4094", 32'(rx_if.debugbus), 32'h47FE);
    rx_if.channels = 4'd4;
    send_frame(0);
    check_eq("full_drop", 32'(rx_if.debugbus), 32'hC7FE);
    tick();
    check_eq("full_drop_hold", 32'(rx_if.debugbus), 32'hC7FE);
    rx_if.clear_status = 1'b1;
    tick();
    rx_if.clear_status = 1'b0;
    check_eq("ovf_clear", 32'(rx_if.overflow), 32'h0);
    rx_if.channels = 4'd2;
    send_frame(2);
    check_eq("full_4096", 32'(rx_if.debugbus), 32'h5000);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("full_reset", 32'(rx_if.debugbus), 32'h2000);

    // strobe during PACK drops the second frame, first stays intact
    rx_if.channels = 4'd8;
    set_din(16'h0010);
    rx_if.strobe = 1'b1;
    tick();
    set_din(16'h0990);
    tick();
    rx_if.strobe = 1'b0;
    check_eq("b2b_ovf", 32'(rx_if.overflow), 32'h1);
    repeat (7) tick();
    check_eq("b2b_dbg", 32'(rx_if.debugbus), 32'h8008);
    for (int i = 0; i < 8; i++) begin
      read_word();
      check_eq("b2b_rd", 32'(rx_if.dout), 32'(16'h0010 + 16'(i)));
    end
    rx_if.clear_status = 1'b1;
    tick();
    rx_if.clear_status = 1'b0;

    // channels=0 writes nothing, channels=15 clamps to 8
    rx_if.channels = 4'd0;
    send_frame(3);
    check_eq("ch0_dbg", 32'(rx_if.debugbus), 32'h2000);
    rx_if.channels = 4'd15;
    set_din(16'h0A00);
    send_frame(8);
    check_eq("ch15_dbg", 32'(rx_if.debugbus), 32'h0008);
    for (int i = 0; i < 8; i++) begin
      read_word();
      check_eq("ch15_rd", 32'(rx_if.dout), 32'(16'h0A00 + 16'(i)));
    end
    read_word();
    check_eq("empty_rd_dout", 32'(rx_if.dout), 32'h0A07);
    check_eq("empty_rd_dbg", 32'(rx_if.debugbus), 32'h2000);

    // bus_reset mid-frame aborts it; strobe in the reset cycle is ignored
    rx_if.channels = 4'd8;
    set_din(16'h0B00);
    send_frame(3);
    check_eq("br_mid", 32'(rx_if.debugbus), 32'h0803);
    bus_reset    = 1'b1;
    rx_if.strobe = 1'b1;
    tick();
    bus_reset    = 1'b0;
    rx_if.strobe = 1'b0;
    check_eq("br_dbg", 32'(rx_if.debugbus), 32'h2000);
    check_eq("br_dout", 32'(rx_if.dout), 32'h0000);
    repeat (10) tick();
    check_eq("br_idle", 32'(rx_if.debugbus), 32'h2000);
    read_word();
    check_eq("br_empty_rd", 32'(rx_if.dout), 32'h0000);
    check_eq("br_prdy", 32'(rx_if.packet_rdy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_sample_packer.md
# rx_sample_packer

Single-clock receive buffer. On each decimated sample strobe it captures up to eight 16-bit channel samples and serialises the active channels, in channel order, into one FIFO. It presents the data as fixed-size packets to the USB-side reader. It sits between the DDC/decimation stage (strobe generator) and the FX2 interface model.

## Interface
Parameters:
- DEPTH_LOG2, 12: FIFO depth is 2^DEPTH_LOG2 16-bit words (4096).
- PKT_WORDS, 256: words per USB packet (512 bytes).

Ports:
- clk, in, 1: single clock for the write and read sides.
- reset, in, 1: synchronous, active-high. Clears the FIFO, the packer state and overflow.
- bus_reset, in, 1: synchronous, active-high. Same effect as reset.
- strobe, in, 1: one-cycle sample-valid pulse.
- channels, in, 4: number of active channels. 1–8 valid, 0 means none, values above 8 clamp to 8.
- din0..din7, in, 16 each: channel samples, sampled on the strobe cycle.
- rd_req, in, 1: read one word.
- dout, out, 16: read data, registered.
- packet_rdy, out, 1: high when at least PKT_WORDS words are stored.
- overflow, out, 1: sticky; set when a sample frame is lost.
- clear_status, in, 1: clears overflow.
- debugbus, out, 16: status word.

## Operation
- Write side has two states, IDLE and PACK.
- IDLE with strobe:
  - Latch din0..din7 and ch_cnt = min(channels, 8).
  - If ch_cnt = 0, no action.
  - If free space ≥ ch_cnt, go to PACK.
  - Otherwise drop the whole frame and set overflow. No partial frames are ever written.
- PACK:
  - Write latched din[idx] with idx starting at 0, one word per clock.
  - After the write of idx = ch_cnt-1, return to IDLE.
- Strobe during PACK: the new frame is dropped, overflow is set and the current frame completes.
- Read side:
  - rd_req with the FIFO non-empty pops the head word into dout.
  - rd_req with the FIFO empty is ignored: dout holds and no underflow occurs.
- Occupancy count:
  - Simultaneous write and read leaves the count unchanged.
  - Pointers wrap modulo 2^DEPTH_LOG2.
  - Full is count = 2^DEPTH_LOG2. Empty is count = 0.
- packet_rdy is combinational from the count: count ≥ PKT_WORDS.
- overflow:
  - Set when a frame is dropped.
  - Cleared by clear_status, reset or bus_reset.
  - Set wins over a simultaneous clear_status.
- debugbus = {overflow, packet_rdy, empty, full, pack_busy, count[10:0]}.

## Timing
- First word of a frame is written on the cycle after strobe. Frame write ends strobe+ch_cnt cycles later.
- Written data is readable one cycle after the write cycle.
- dout is valid the cycle after an accepted rd_req.
- Reset values: dout=0, overflow=0, packet_rdy=0, count=0, state=IDLE, debugbus=0x0000 except field bits derived from the count (all zero).
- reset or bus_reset mid-frame aborts the frame and discards stored words. Strobe in the reset cycle is ignored.
- Free-space check is done in the strobe cycle. A concurrent read in that cycle is not credited.

## Structure
- Shared package `rx_buf_pkg`:
  - MAX_CH = 8
  - default PKT_WORDS = 256
  - default DEPTH_LOG2 = 12
  - state enum {IDLE, PACK}
- Natural sub-module `sync_fifo_16`: single-clock RAM FIFO with wr_en/rd_en, dout register, count/full/empty.
- The top level holds the packer FSM, the channel mux, the overflow logic and the debug bus.

## Test plan
- Reset, then channels=4, din0..3=0x0001..0x0004, one strobe → four writes on cycles +1..+4; reading 4 words returns 1,2,3,4 in order; packet_rdy stays 0.
- channels=4, strobe every 64 clocks, 64 strobes → count reaches 256 exactly after the 64th frame and packet_rdy rises then; 256 reads return the frames in order and packet_rdy falls after the first read.
- No reads until count=4094, then strobe with channels=4 → frame dropped, count stays 4094, overflow=1; clear_status → overflow=0.
- Strobe on the cycle after a channels=8 strobe → second frame dropped, overflow=1, first frame's 8 words intact.
- channels=0 → no writes; channels=15 → 8 words written.
- bus_reset mid-frame and rd_req when empty → count=0, packet_rdy=0, dout unchanged by the empty read.
